// File: rtl/vector_pkg.sv
// vector_pkg: shared types and defaults for the vector operand fetch slice.
package vector_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int DEFAULT_VLEN = 256;

    typedef logic [REG_ADDR_W-1:0] vreg_addr_t;

    typedef enum logic {
        IDLE,
        FETCH_C
    } fetch_state_e;

endpackage

// File: rtl/vrf_bypass_mux.sv
// vrf_bypass_mux: read value for one register-file port.
// Register 0 reads as zero; otherwise a same-cycle write wins over the stale file data.
module vrf_bypass_mux
    import vector_pkg::*;
#(
    parameter int VLEN = DEFAULT_VLEN
) (
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [VLEN-1:0]       rdata_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic [VLEN-1:0]       wb_wdata_i,
    output logic [VLEN-1:0]       data_o
);

    always_comb begin
        data_o = (addr_i == '0) ? '0 :
                 (wb_we_i && wb_waddr_i == addr_i) ? wb_wdata_i : rdata_i;
    end

endmodule

// File: rtl/vector_operand_fetch.sv
// vector_operand_fetch: reads up to three vector operands through two regfile ports,
// forwarding same-cycle writebacks, and presents them as one registered bundle.
module vector_operand_fetch
    import vector_pkg::*;
#(
    parameter int VLEN     = DEFAULT_VLEN,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [REG_ADDR_W-1:0] req_vs1_i,
    input  logic [REG_ADDR_W-1:0] req_vs2_i,
    input  logic [REG_ADDR_W-1:0] req_vd_i,
    input  logic                  req_use_vd_i,
    input  logic [TAG_W-1:0]      req_tag_i,
    output logic [REG_ADDR_W-1:0] raddr1_o,
    input  logic [VLEN-1:0]       rdata1_i,
    output logic [REG_ADDR_W-1:0] raddr2_o,
    input  logic [VLEN-1:0]       rdata2_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic [VLEN-1:0]       wb_wdata_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [VLEN-1:0]       op_a_o,
    output logic [VLEN-1:0]       op_b_o,
    output logic [VLEN-1:0]       op_c_o,
    output logic [TAG_W-1:0]      op_tag_o,
    output logic                  busy_o
);

    fetch_state_e          state_q, state_d;
    logic                  op_valid_q, op_valid_d;
    logic [VLEN-1:0]       op_a_q, op_a_d;
    logic [VLEN-1:0]       op_b_q, op_b_d;
    logic [VLEN-1:0]       op_c_q, op_c_d;
    logic [TAG_W-1:0]      op_tag_q, op_tag_d;
    logic [REG_ADDR_W-1:0] vd_q, vd_d;
    logic [TAG_W-1:0]      tag_q, tag_d;

    logic                  free, accept, wb_en;
    logic [VLEN-1:0]       rd1, rd2;

    // Writes to addresses beyond the architectural file are never forwarded.
    assign wb_en = wb_we_i && (int'(wb_waddr_i) < NUM_REGS);

    vrf_bypass_mux #(.VLEN(VLEN)) u_port1 (
        .addr_i     (raddr1_o),
        .rdata_i    (rdata1_i),
        .wb_we_i    (wb_en),
        .wb_waddr_i (wb_waddr_i),
        .wb_wdata_i (wb_wdata_i),
        .data_o     (rd1)
    );

    vrf_bypass_mux #(.VLEN(VLEN)) u_port2 (
        .addr_i     (raddr2_o),
        .rdata_i    (rdata2_i),
        .wb_we_i    (wb_en),
        .wb_waddr_i (wb_waddr_i),
        .wb_wdata_i (wb_wdata_i),
        .data_o     (rd2)
    );

    always_comb begin
        free        = !op_valid_q || op_ready_i;
        req_ready_o = (state_q == IDLE) && free;
        accept      = req_valid_i && req_ready_o;
        raddr1_o    = (state_q == FETCH_C) ? vd_q : req_vs1_i;
        raddr2_o    = (state_q == FETCH_C) ? '0 : req_vs2_i;
        state_d     = state_q;
        op_valid_d  = (op_valid_q && op_ready_i) ? 1'b0 : op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_tag_d    = op_tag_q;
        vd_d        = vd_q;
        tag_d       = tag_q;
        if (state_q == FETCH_C) begin
            // Second read cycle: port 1 now carries vd, port 2 is parked on x0.
            op_c_d     = rd1;
            op_tag_d   = tag_q;
            op_valid_d = 1'b1;
            state_d    = IDLE;
        end else if (accept) begin
            op_a_d = rd1;
            op_b_d = rd2;
            tag_d  = req_tag_i;
            if (req_use_vd_i) begin
                vd_d       = req_vd_i;
                op_valid_d = 1'b0;
                state_d    = FETCH_C;
            end else begin
                op_c_d     = '0;
                op_tag_d   = req_tag_i;
                op_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            op_tag_q   <= '0;
            vd_q       <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            op_tag_q   <= op_tag_d;
            vd_q       <= vd_d;
            tag_q      <= tag_d;
        end
    end

    assign op_valid_o = op_valid_q;
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;
    assign op_c_o     = op_c_q;
    assign op_tag_o   = op_tag_q;
    assign busy_o     = (state_q == FETCH_C);

endmodule

// File: tb/tb_vector_operand_fetch.sv
// tb_vector_operand_fetch: drives issue requests against a behavioural register file
// and checks each emitted operand bundle against a queue of expected bundles.
module tb_vector_operand_fetch;

    localparam int VLEN  = 256;
    localparam int TAG_W = 8;

    typedef struct {
        logic [VLEN-1:0]  a;
        logic [VLEN-1:0]  b;
        logic [VLEN-1:0]  c;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             req_valid_i, req_ready_o;
    logic [4:0]       req_vs1_i, req_vs2_i, req_vd_i;
    logic             req_use_vd_i;
    logic [TAG_W-1:0] req_tag_i;
    logic [4:0]       raddr1_o, raddr2_o;
    logic [VLEN-1:0]  rdata1_i, rdata2_i;
    logic             wb_we_i;
    logic [4:0]       wb_waddr_i;
    logic [VLEN-1:0]  wb_wdata_i;
    logic             op_valid_o, op_ready_i;
    logic [VLEN-1:0]  op_a_o, op_b_o, op_c_o;
    logic [TAG_W-1:0] op_tag_o;
    logic             busy_o;

    logic [VLEN-1:0]  regs [32] = '{default: '0};
    exp_t             exp_q [$];
    int               tests_run = 0;
    int               tests_failed = 0;

    vector_operand_fetch #(.VLEN(VLEN), .NUM_REGS(32), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_vs1_i(req_vs1_i), .req_vs2_i(req_vs2_i), .req_vd_i(req_vd_i),
        .req_use_vd_i(req_use_vd_i), .req_tag_i(req_tag_i),
        .raddr1_o(raddr1_o), .rdata1_i(rdata1_i),
        .raddr2_o(raddr2_o), .rdata2_i(rdata2_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o),
        .op_tag_o(op_tag_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file model: combinational reads, writes land on the clock edge.
    assign rdata1_i = regs[raddr1_o];
    assign rdata2_i = regs[raddr2_o];
    always @(posedge clk_i) if (wb_we_i) regs[wb_waddr_i] <= wb_wdata_i;

    // Scoreboard: every handshake must match the oldest expected bundle.
    always @(negedge clk_i) begin
        if (rst_ni && op_valid_o && op_ready_i) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL bundle_unexpected: got tag %0h, none expected", op_tag_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({op_a_o, op_b_o, op_c_o, op_tag_o} !== {e.a, e.b, e.c, e.tag}) begin
                    tests_failed++;
                    $display("FAIL bundle_tag%0h: got a=%h b=%h c=%h tag=%h, want a=%h b=%h c=%h tag=%h",
                             e.tag, op_a_o[31:0], op_b_o[31:0], op_c_o[31:0], op_tag_o,
                             e.a[31:0], e.b[31:0], e.c[31:0], e.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [VLEN-1:0] fill(input logic [7:0] b);
        return {(VLEN/8){b}};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a, b, c, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.a = fill(a);
        e.b = fill(b);
        e.c = fill(c);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input logic [4:0] s1, s2, vd, input logic use_vd, input logic [TAG_W-1:0] tag);
        req_valid_i  = 1'b1;
        req_vs1_i    = s1;
        req_vs2_i    = s2;
        req_vd_i     = vd;
        req_use_vd_i = use_vd;
        req_tag_i    = tag;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [7:0] b);
        wb_we_i    = 1'b1;
        wb_waddr_i = addr;
        wb_wdata_i = fill(b);
        step();
        wb_we_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_vs1_i = '0; req_vs2_i = '0; req_vd_i = '0;
        req_use_vd_i = 1'b0; req_tag_i = '0;
        wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        op_ready_i = 1'b1;
        #1;
        tests_run++;
        if ({op_valid_o, busy_o, op_a_o, op_b_o, op_c_o, op_tag_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b busy=%b tag=%h, want all zero", op_valid_o, busy_o, op_tag_o);
        end
        tests_run++;
        if (req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        write_reg(5'd1, 8'h11);
        write_reg(5'd2, 8'h22);
        write_reg(5'd3, 8'h33);
    endtask

    task automatic test_two_op();
        drive_req(5'd1, 5'd2, 5'd0, 1'b0, 8'h05);
        push_exp(8'h11, 8'h22, 8'h00, 8'h05);
        step();
        req_valid_i = 1'b0;
        tests_run++;
        if (op_valid_o !== 1'b1 || op_tag_o !== 8'h05) begin
            tests_failed++;
            $display("FAIL two_op_latency: got valid=%b tag=%h, want 1/05", op_valid_o, op_tag_o);
        end
        step();
    endtask

    task automatic test_three_op();
        drive_req(5'd1, 5'd2, 5'd3, 1'b1, 8'h07);
        push_exp(8'h11, 8'h22, 8'h33, 8'h07);
        tests_run++;
        if (raddr1_o !== 5'd1 || raddr2_o !== 5'd2) begin
            tests_failed++;
            $display("FAIL three_op_raddr_idle: got %0d/%0d want 1/2", raddr1_o, raddr2_o);
        end
        step();
        tests_run++;
        if ({busy_o, req_ready_o, op_valid_o, raddr1_o, raddr2_o} !== {1'b1, 1'b0, 1'b0, 5'd3, 5'd0}) begin
            tests_failed++;
            $display("FAIL three_op_fetch_c: got busy=%b ready=%b valid=%b ra1=%0d ra2=%0d, want 1 0 0 3 0",
                     busy_o, req_ready_o, op_valid_o, raddr1_o, raddr2_o);
        end
        req_valid_i = 1'b0;
        step();
        tests_run++;
        if (op_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL three_op_done: got valid=%b busy=%b want 1/0", op_valid_o, busy_o);
        end
        step();
    endtask

    task automatic test_bypass();
        drive_req(5'd0, 5'd2, 5'd0, 1'b0, 8'h09);
        wb_we_i = 1'b1; wb_waddr_i = 5'd2; wb_wdata_i = fill(8'hAB);
        push_exp(8'h00, 8'hAB, 8'h00, 8'h09);
        step();
        drive_req(5'd0, 5'd1, 5'd0, 1'b0, 8'h0A);
        wb_waddr_i = 5'd0; wb_wdata_i = fill(8'hCD);
        push_exp(8'h00, 8'h11, 8'h00, 8'h0A);
        step();
        wb_we_i = 1'b0;
        drive_req(5'd1, 5'd0, 5'd3, 1'b1, 8'h0B);
        push_exp(8'h11, 8'h00, 8'hEE, 8'h0B);
        step();
        req_valid_i = 1'b0;
        wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = fill(8'hEE);
        step();
        wb_we_i = 1'b0;
        tests_run++;
        if (op_c_o !== fill(8'hEE)) begin
            tests_failed++;
            $display("FAIL bypass_fetch_c: got %h want %h", op_c_o[31:0], 32'hEEEEEEEE);
        end
        step();
    endtask

    task automatic test_backpressure();
        op_ready_i = 1'b0;
        drive_req(5'd1, 5'd2, 5'd0, 1'b0, 8'h20);
        push_exp(8'h11, 8'hAB, 8'h00, 8'h20);
        step();
        drive_req(5'd3, 5'd1, 5'd0, 1'b0, 8'h21);
        wb_we_i = 1'b1; wb_waddr_i = 5'd1; wb_wdata_i = fill(8'h5A);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({op_valid_o, req_ready_o, op_a_o, op_tag_o} !== {1'b1, 1'b0, fill(8'h11), 8'h20}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: got valid=%b ready=%b a=%h tag=%h, want 1 0 11111111 20",
                         i, op_valid_o, req_ready_o, op_a_o[31:0], op_tag_o);
            end
            step();
            wb_we_i = 1'b0;
        end
        push_exp(8'hEE, 8'h5A, 8'h00, 8'h21);
        op_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        tests_run++;
        if (op_valid_o !== 1'b1 || op_tag_o !== 8'h21) begin
            tests_failed++;
            $display("FAIL stall_release_no_bubble: got valid=%b tag=%h want 1/21", op_valid_o, op_tag_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [TAG_W-1:0] t;
            t = 8'h30 + 8'(i);
            if (i % 2 == 0) begin
                drive_req(5'd1, 5'd2, 5'd0, 1'b0, t);
                push_exp(8'h5A, 8'hAB, 8'h00, t);
            end else begin
                drive_req(5'd2, 5'd1, 5'd0, 1'b0, t);
                push_exp(8'hAB, 8'h5A, 8'h00, t);
            end
            tests_run++;
            if (req_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, req_ready_o);
            end
            step();
            tests_run++;
            if (op_valid_o !== 1'b1 || op_tag_o !== t) begin
                tests_failed++;
                $display("FAIL b2b_bundle_%0d: got valid=%b tag=%h want 1/%h", i, op_valid_o, op_tag_o, t);
            end
        end
        req_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_fetch();
        drive_req(5'd1, 5'd2, 5'd3, 1'b1, 8'h40);
        step();
        req_valid_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_in_fetch_c: got busy=%b want 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (op_valid_o !== 1'b0 || busy_o !== 1'b0 || op_a_o !== '0) begin
            tests_failed++;
            $display("FAIL midrst_immediate: got valid=%b busy=%b a=%h want 0 0 0", op_valid_o, busy_o, op_a_o[31:0]);
        end
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (op_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_dropped_%0d: got valid=%b busy=%b want 0/0", i, op_valid_o, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_op();
        test_three_op();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fetch();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d bundles outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vector_operand_fetch.md
Name: vector_operand_fetch

Overview:
- Read-side client of the vector register file: accepts issued vector ops, drives both combinational read ports, and registers up to three VLEN-bit operands for the execute stage.
- Three-operand ops (e.g. vmacc, where vd is also a source) need a second read cycle, because the file has only two read ports.
- Snoops the file's write port and forwards same-cycle writes. The file updates on the clock edge, so a same-cycle read would otherwise return the stale value.
- Sits between issue/scoreboard and execute. Upstream scoreboard guarantees no RAW hazard on writes still in flight.

Parameters:
- VLEN, 256, vector register width in bits
- NUM_REGS, 32, architectural register count; address width is 5
- TAG_W, 8, opaque instruction tag width, carried through unchanged

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- req_valid_i  in  1  issue request valid
- req_ready_o  out  1  issue request accepted when valid&&ready
- req_vs1_i  in  5  source register A
- req_vs2_i  in  5  source register B
- req_vd_i  in  5  third source (destination-as-source)
- req_use_vd_i  in  1  op needs third operand
- req_tag_i  in  TAG_W  instruction tag
- raddr1_o  out  5  regfile read port 1 address
- rdata1_i  in  VLEN  regfile read port 1 data (combinational)
- raddr2_o  out  5  regfile read port 2 address
- rdata2_i  in  VLEN  regfile read port 2 data
- wb_we_i  in  1  snooped regfile write enable
- wb_waddr_i  in  5  snooped write address
- wb_wdata_i  in  VLEN  snooped write data
- op_valid_o  out  1  operand bundle valid
- op_ready_i  in  1  execute stage accepts bundle
- op_a_o  out  VLEN  operand from vs1
- op_b_o  out  VLEN  operand from vs2
- op_c_o  out  VLEN  operand from vd; 0 when use_vd=0
- op_tag_o  out  TAG_W  tag of bundle
- busy_o  out  1  high in FETCH_C

Behaviour:
- States: IDLE, FETCH_C. Reset: state=IDLE; op_valid_o=0; op_a/b/c=0; op_tag=0; internal vd_q/tag_q=0.
- Output slot free: free = !op_valid_o || op_ready_i.
- req_ready_o = (state==IDLE) && free, combinational.
- raddr outputs, combinational:
  - IDLE: raddr1_o=req_vs1_i, raddr2_o=req_vs2_i.
  - FETCH_C: raddr1_o=vd_q, raddr2_o=0.
- Per-port read value:
  - address 0 → 0, regardless of rdata or snoop;
  - else if wb_we_i && wb_waddr_i==addr → wb_wdata_i (bypass);
  - else rdata.
- Writes to address 0 are never forwarded.
- Accept in IDLE:
  - Register op_a, op_b and tag.
  - use_vd=0: op_c<=0, op_valid<=1, stay IDLE. Latency is 1 cycle, throughput 1 per cycle.
  - use_vd=1: vd_q<=req_vd_i, op_valid<=0, go to FETCH_C.
- FETCH_C (one cycle, unconditional):
  - op_c<=port-1 value, op_valid<=1, go to IDLE.
  - Throughput for 3-operand ops is 1 per 2 cycles.
- Invariant: op_valid_o=0 whenever state==FETCH_C.
- Output handshake:
  - op_valid_o && op_ready_i with no new completion → op_valid<=0.
  - Consumption and a new completion in the same cycle → op_valid stays 1 with the new bundle; no bubble.
- Stall: op_valid_o && !op_ready_i → all op_* outputs held stable; req_ready_o=0.
- Captured operands are a snapshot: writes after the read cycle do not alter held op_a/b/c.
- Reset asserted mid-operation: immediate return to reset values; a partially fetched op is dropped.

Decomposition:
- vector_pkg holds:
  - REG_ADDR_W=5, default VLEN;
  - typedef vreg_addr_t;
  - enum fetch_state_e {IDLE, FETCH_C}.
- Sub-module vrf_bypass_mux: zero/bypass/rdata select for one read port; instantiated twice, parameterized by VLEN.

Test Plan:
- Reset and 2-op issue:
  - stimulus: reset, then v1=0x11..11, v2=0x22..22 preloaded; issue vs1=1, vs2=2, use_vd=0, tag=0x05, op_ready=1;
  - response: next cycle op_valid=1, op_a=0x11..11, op_b=0x22..22, op_c=0, tag=0x05.
- 3-op issue:
  - stimulus: vs1=1, vs2=2, vd=3 with v3=0x33..33;
  - response: req_ready low and busy=1 for 1 cycle, raddr1=3; op_valid rises 2 cycles after accept with op_c=0x33..33.
- Bypass and zero:
  - stimulus: same cycle as accept, wb_we=1, waddr=2, wdata=0xAB..AB; vs1=0;
  - response: op_b=0xAB..AB, op_a=0.
  - Repeat with waddr=0 and vs1=0 → op_a=0.
- Backpressure:
  - stimulus: op_ready=0 for 3 cycles with bundle valid, req_valid held;
  - response: outputs stable, req_ready=0; op_ready=1 → new bundle next cycle, no bubble.
- Back-to-back throughput:
  - stimulus: 4 consecutive 2-op requests, op_ready=1;
  - response: 4 bundles on 4 consecutive cycles, tags in order.
- Reset mid-FETCH_C:
  - stimulus: assert rst_ni low during FETCH_C;
  - response: op_valid=0 immediately, state IDLE, no bundle emitted after release.
